ines_loader: RTL
================

Name: ines_loader

Overview:
Streams an iNES image (16-byte header, optional trainer, PRG ROM, CHR ROM) from a byte source. Parses the header into the static cartridge configuration consumed by the mapper: mirrorv, chr_ram, prg_ram, masks and mapper number. Writes PRG and CHR bytes into the cartridge ROM memories. Holds the cartridge/mapper in reset until the image is fully loaded.

Parameters:
PRG_ROM_DEPTH, 17, PRG ROM byte-address width (128 KB).
CHR_ROM_DEPTH, 15, CHR ROM byte-address width (32 KB).
PRG_RAM_DEPTH, 13, PRG RAM byte-address width (8 KB).

Ports:
clk_cpu  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
start  in  1  one-cycle pulse: abort any load and begin parsing a new image.
in_data  in  8  image byte.
in_valid  in  1  in_data valid.
in_ready  out  1  loader accepts in_data this cycle.
prg_we  out  1  PRG ROM write strobe.
chr_we  out  1  CHR ROM write strobe.
wr_addr  out  max(PRG_ROM_DEPTH,CHR_ROM_DEPTH)  write byte address (upper bits zero for CHR).
wr_data  out  8  write data.
mirrorv  out  1  header byte6[0].
prg_ram  out  1  header byte6[1].
chr_ram  out  1  1 when CHR size byte is 0.
mapper_num  out  8  {byte7[7:4], byte6[7:4]}.
prg_mask  out  PRG_ROM_DEPTH  PRG address mask.
chr_mask  out  CHR_ROM_DEPTH  CHR address mask.
prgram_mask  out  PRG_RAM_DEPTH  all ones.
cart_rst  out  1  high unless state is DONE.
done  out  1  image loaded.
error  out  1  load failed.

Behaviour:
- Accept: a byte is accepted when in_valid && in_ready. in_ready is high only in HDR, TRN, PRG and CHR.
- Reset values: all outputs 0, except cart_rst=1 and prgram_mask all ones. State is IDLE.
- States: IDLE, HDR, TRN, PRG, CHR, DONE, ERR.
- start: from any state, go to HDR, clear counters, done and error. cart_rst is forced to 1 in the same cycle. start takes priority over a simultaneous byte accept; that byte is dropped.
- HDR: 16 bytes, indexed 0-15.
  - Bytes 0-3 must equal 4E 45 53 1A. On mismatch go to ERR on that byte.
  - Byte 4 = prg_units (16 KB each). Byte 5 = chr_units (8 KB each). Bytes 6 and 7 are latched into the config outputs as they arrive. Bytes 8-15 are ignored.
  - After byte 15: if byte6[2] is set, go to TRN. Otherwise go to PRG.
- Size checks, evaluated after byte 15:
  - prg_units==0, or prg_units*16K > 2^PRG_ROM_DEPTH: go to ERR.
  - chr_units*8K > 2^CHR_ROM_DEPTH: go to ERR.
- Masks:
  - prg_mask: low 14 bits are ones. Upper bits = right-smear of (prg_units-1), i.e. next power of two minus one. Example: prg_units=3 gives 0xFFFF.
  - chr_mask: low 13 bits are ones; upper bits = right-smear of (chr_units-1). chr_units=0 gives 0x1FFF.
- TRN: see Optional Feature.
- PRG:
  - Each accepted byte produces a prg_we pulse one cycle later, with wr_addr = byte count and wr_data = the byte (registered, latency 1).
  - The counter runs 0 to prg_units*16384-1. After the last byte: go to CHR if chr_units != 0, else DONE.
- CHR: same as PRG, using chr_we and counting 0 to chr_units*8192-1. Then go to DONE.
- DONE: done=1 and cart_rst=0 from the cycle after the final write strobe. The final byte's write strobe is issued while cart_rst is still 1.
- ERR: error=1, in_ready=0, cart_rst=1. Leave only via start or rst.
- Strobes: prg_we and chr_we are never high together. Neither is high in HDR, TRN, IDLE or ERR.
- Stalls: in_valid low between bytes is allowed at any point and does not advance counters.
- Asynchronous rst mid-load: immediate return to reset values. Memory contents are undefined.

Optional Feature:
INES_TRAINER_EN
- Defined: TRN state consumes exactly 512 bytes and discards them, with no write strobes, then goes to PRG.
- Undefined: no TRN state; byte6[2]=1 sends the loader to ERR after header byte 15.

Test Plan:
- Valid NROM image, header 4E 45 53 1A 02 01 01 00 ..., 32768 PRG + 8192 CHR bytes -> first prg_we at addr 0; last prg_we at 0x7FFF; chr_we at 0x0000-0x1FFF; done=1; cart_rst=0; mirrorv=1; prg_mask=0x07FFF; chr_mask=0x1FFF; mapper_num=0.
- MMC1 image, byte4=0x08, byte5=0x00, byte6=0x12 -> prg_mask=0x1FFFF; chr_ram=1; prg_ram=1; mapper_num=0x01; no chr_we; done after 131072 PRG bytes.
- Bad magic, byte 3=0x1B -> error=1 and in_ready=0 the cycle after byte 3; no write strobes; cart_rst stays 1.
- Oversize PRG, byte4=0x09 with PRG_ROM_DEPTH=17 -> error=1 after byte 15; byte4=0x03 -> prg_mask=0x0FFFF and load completes after 49152 bytes.
- start pulsed mid-PRG at byte 1000 -> state HDR, error=0, done=0; a fresh valid image then completes, and its first prg_we is at addr 0.
- byte6=0x04 -> with INES_TRAINER_EN, 512 bytes are skipped and the first prg_we data is byte 528 of the stream; without it, error=1.

Source files
------------

// File: rtl/ines_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ines_loader_if
// Description : Byte-stream input handshake plus ROM write bus of the iNES loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface ines_loader_if #(
    parameter int ADDR_W = 17
) ();
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              prg_we;
    logic              chr_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, prg_we, chr_we, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, prg_we, chr_we, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/ines_loader.sv
`default_nettype none
// ============================================================================
// Module      : ines_loader
// Description : Parses an iNES image stream, writes PRG/CHR ROM and holds the
//               cartridge in reset until loaded. INES_TRAINER_EN enables the
//               512-byte trainer skip (otherwise a trainer image is an error).
// Revision    : 1.0 - initial release
// ============================================================================
module ines_loader #(
    parameter int PRG_ROM_DEPTH = 17,
    parameter int CHR_ROM_DEPTH = 15,
    parameter int PRG_RAM_DEPTH = 13
) (
    input  logic                     clk_cpu,
    input  logic                     rst,
    input  logic                     start,
    ines_loader_if.slave             bus,
    output logic                     mirrorv,
    output logic                     prg_ram,
    output logic                     chr_ram,
    output logic [7:0]               mapper_num,
    output logic [PRG_ROM_DEPTH-1:0] prg_mask,
    output logic [CHR_ROM_DEPTH-1:0] chr_mask,
    output logic [PRG_RAM_DEPTH-1:0] prgram_mask,
    output logic                     cart_rst,
    output logic                     done,
    output logic                     error
);

    localparam int          c_addr_w        = (PRG_ROM_DEPTH > CHR_ROM_DEPTH) ? PRG_ROM_DEPTH : CHR_ROM_DEPTH;
    localparam logic [31:0] c_magic         = 32'h1A53_454E;
    localparam logic [31:0] c_prg_max_units = 32'd1 << (PRG_ROM_DEPTH - 14);
    localparam logic [31:0] c_chr_max_units = 32'd1 << (CHR_ROM_DEPTH - 13);
`ifdef INES_TRAINER_EN
    localparam logic [c_addr_w-1:0] c_trn_last = c_addr_w'(511);
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
`ifdef INES_TRAINER_EN
        S_TRN  = 3'd2,
`endif
        S_PRG  = 3'd3,
        S_CHR  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // Upper mask bits: next power of two of the unit count, minus one.
    function automatic logic [7:0] f_mask_hi(input logic [7:0] units);
        logic [7:0] v;
        v = (units == 8'd0) ? 8'd0 : units - 8'd1;
        v = v | (v >> 1);
        v = v | (v >> 2);
        v = v | (v >> 4);
        return v;
    endfunction

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [3:0]               r_hdr_idx;
    logic [c_addr_w-1:0]      r_cnt;
    logic [7:0]               r_prg_units;
    logic [7:0]               r_chr_units;
    logic                     r_mirrorv;
    logic                     r_prg_ram;
    logic                     r_trainer;
    logic                     r_chr_ram;
    logic [3:0]               r_mapper_lo;
    logic [3:0]               r_mapper_hi;
    logic [PRG_ROM_DEPTH-1:0] r_prg_mask;
    logic [CHR_ROM_DEPTH-1:0] r_chr_mask;
    logic                     r_prg_we;
    logic                     r_chr_we;
    logic [c_addr_w-1:0]      r_wr_addr;
    logic [7:0]               r_wr_data;
    logic                     r_done;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_cnt_last;
    logic                     w_size_bad;
    logic [7:0]               w_magic_byte;
    logic [c_addr_w-1:0]      w_prg_last;
    logic [c_addr_w-1:0]      w_chr_last;

    assign w_magic_byte = c_magic[{r_hdr_idx[1:0], 3'b000} +: 8];
    assign w_prg_last   = c_addr_w'({r_prg_units - 8'd1, 14'h3FFF});
    assign w_chr_last   = c_addr_w'({r_chr_units - 8'd1, 13'h1FFF});
    assign w_size_bad   = (r_prg_units == 8'd0)
                       || ({24'd0, r_prg_units} > c_prg_max_units)
                       || ({24'd0, r_chr_units} > c_chr_max_units);

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_cnt_last  = 1'b0;
        case (r_state)
            S_HDR: w_in_ready = 1'b1;
`ifdef INES_TRAINER_EN
            S_TRN: begin
                w_in_ready = 1'b1;
                w_cnt_last = (r_cnt == c_trn_last);
            end
`endif
            S_PRG: begin
                w_in_ready = 1'b1;
                w_cnt_last = (r_cnt == w_prg_last);
            end
            S_CHR: begin
                w_in_ready = 1'b1;
                w_cnt_last = (r_cnt == w_chr_last);
            end
            default: ;
        endcase

        w_accept = bus.in_valid && w_in_ready && !start;

        if (w_accept) begin
            case (r_state)
                S_HDR: begin
                    if (r_hdr_idx < 4'd4 && bus.in_data != w_magic_byte) begin
                        w_state_nxt = S_ERR;
                    end else if (r_hdr_idx == 4'd15) begin
                        if (w_size_bad) begin
                            w_state_nxt = S_ERR;
                        end else if (r_trainer) begin
`ifdef INES_TRAINER_EN
                            w_state_nxt = S_TRN;
`else
                            w_state_nxt = S_ERR;
`endif
                        end else begin
                            w_state_nxt = S_PRG;
                        end
                    end
                end
`ifdef INES_TRAINER_EN
                S_TRN: if (w_cnt_last) w_state_nxt = S_PRG;
`endif
                S_PRG: if (w_cnt_last) w_state_nxt = (r_chr_units != 8'd0) ? S_CHR : S_DONE;
                S_CHR: if (w_cnt_last) w_state_nxt = S_DONE;
                default: ;
            endcase
        end

        if (start) begin
            w_state_nxt = S_HDR;
        end
    end

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hdr_idx   <= 4'd0;
            r_cnt       <= '0;
            r_prg_units <= 8'd0;
            r_chr_units <= 8'd0;
            r_mirrorv   <= 1'b0;
            r_prg_ram   <= 1'b0;
            r_trainer   <= 1'b0;
            r_chr_ram   <= 1'b0;
            r_mapper_lo <= 4'd0;
            r_mapper_hi <= 4'd0;
            r_prg_mask  <= '0;
            r_chr_mask  <= '0;
            r_prg_we    <= 1'b0;
            r_chr_we    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'd0;
            r_done      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // done trails the final write strobe by one cycle
            r_done   <= (r_state == S_DONE) && !start;
            r_prg_we <= w_accept && (r_state == S_PRG);
            r_chr_we <= w_accept && (r_state == S_CHR);
            if (w_accept && (r_state == S_PRG || r_state == S_CHR)) begin
                r_wr_addr <= r_cnt;
                r_wr_data <= bus.in_data;
            end
            if (start) begin
                r_hdr_idx <= 4'd0;
                r_cnt     <= '0;
            end else if (w_accept) begin
                if (r_state == S_HDR) begin
                    r_hdr_idx <= r_hdr_idx + 4'd1;
                    case (r_hdr_idx)
                        4'd4: begin
                            r_prg_units <= bus.in_data;
                            r_prg_mask  <= (PRG_ROM_DEPTH'(f_mask_hi(bus.in_data)) << 14)
                                         | PRG_ROM_DEPTH'(14'h3FFF);
                        end
                        4'd5: begin
                            r_chr_units <= bus.in_data;
                            r_chr_ram   <= (bus.in_data == 8'd0);
                            r_chr_mask  <= (CHR_ROM_DEPTH'(f_mask_hi(bus.in_data)) << 13)
                                         | CHR_ROM_DEPTH'(13'h1FFF);
                        end
                        4'd6: begin
                            r_mirrorv   <= bus.in_data[0];
                            r_prg_ram   <= bus.in_data[1];
                            r_trainer   <= bus.in_data[2];
                            r_mapper_lo <= bus.in_data[7:4];
                        end
                        4'd7: r_mapper_hi <= bus.in_data[7:4];
                        default: ;
                    endcase
                end else begin
                    r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.prg_we   = r_prg_we;
    assign bus.chr_we   = r_chr_we;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign mirrorv      = r_mirrorv;
    assign prg_ram      = r_prg_ram;
    assign chr_ram      = r_chr_ram;
    assign mapper_num   = {r_mapper_hi, r_mapper_lo};
    assign prg_mask     = r_prg_mask;
    assign chr_mask     = r_chr_mask;
    assign prgram_mask  = '1;
    assign cart_rst     = !r_done || start;
    assign done         = r_done;
    assign error        = (r_state == S_ERR);

endmodule
`default_nettype wire
